branch_unit_ras: RTL

Parametrised successor to the single-issue branch unit.
- Resolves RV32I conditional branches, JAL and JALR at configurable XLEN.
- Owns the architectural PC and a circular return-address stack (RAS) of configurable depth.
- Uses a valid/ready handshake plus a post-redirect flush window, so it sits between decode and fetch in the core.

---
 rtl/branch_unit_ras_if.sv | 26 ++
 rtl/branch_unit_ras.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_unit_ras_if.sv
// Decode-to-branch-unit handshake and result bus.
// Master is the upstream decode stage; slave is branch_unit_ras.
interface branch_unit_ras_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [XLEN-1:0] op3;
   logic            out_valid;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] ret_addr;
   logic            redirect;

   modport master (
      output in_valid, instr, op1, op2, op3,
      input  in_ready, out_valid, pc_out, ret_addr, redirect
   );

   modport slave (
      input  in_valid, instr, op1, op2, op3,
      output in_ready, out_valid, pc_out, ret_addr, redirect
   );
endinterface

// File: rtl/branch_unit_ras.sv
// Branch unit with architectural PC and circular return-address stack.
// Resolves RV32I branches, JAL and JALR; holds in_ready low for a flush
// window after every redirect.
// Optional build macro RAS_PREDICT_EN adds ras_top / ras_mispredict outputs.
module branch_unit_ras #(
   parameter int unsigned    XLEN         = 32,
   parameter int unsigned    RAS_DEPTH    = 8,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int unsigned    FLUSH_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   branch_unit_ras_if.slave           bus,
   output logic [$clog2(RAS_DEPTH):0] ras_count,
   output logic                       ras_overflow,
   output logic                       ras_underflow
`ifdef RAS_PREDICT_EN
   ,
   output logic [XLEN-1:0]            ras_top,
   output logic                       ras_mispredict
`endif
);

   localparam int unsigned PW = $clog2(RAS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;

   state_t          state;
   logic [FW-1:0]   flush_cnt;
   logic [6:0]      opc_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q;
   logic [4:0]      rs1_q;
   logic [XLEN-1:0] op1_q;
   logic [XLEN-1:0] op2_q;
   logic [XLEN-1:0] op3_q;
   logic [XLEN-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]   ras_ptr;
   logic [PW-1:0]   top_idx;

   logic            is_br, is_jal, is_jalr, cond;
   logic            rd_link, rs1_link, do_push, do_pop, redir;
   logic [XLEN-1:0] pc_plus4, next_pc, jalr_sum;

   // Only the decoded fields of the instruction word are consumed.
   logic unused_instr_bits;
   assign unused_instr_bits = ^bus.instr[31:20];

   assign top_idx = ras_ptr - PW'(1);

`ifdef RAS_PREDICT_EN
   // Top-of-stack view, zero while the stack is empty.
   assign ras_top = (ras_count == '0) ? '0 : ras_mem[top_idx];
`endif

   // Resolve the captured instruction: condition, next PC and RAS action.
   always_comb begin
      is_br    = (opc_q == OP_BRANCH);
      is_jal   = (opc_q == OP_JAL);
      is_jalr  = (opc_q == OP_JALR);
      cond     = 1'b0;
      pc_plus4 = bus.pc_out + XLEN'(4);
      jalr_sum = op1_q + op3_q;
      next_pc  = pc_plus4;
      case (f3_q)
         3'b000:  cond = (op1_q == op2_q);
         3'b001:  cond = (op1_q != op2_q);
         3'b100:  cond = ($signed(op1_q) <  $signed(op2_q));
         3'b101:  cond = ($signed(op1_q) >= $signed(op2_q));
         3'b110:  cond = (op1_q <  op2_q);
         3'b111:  cond = (op1_q >= op2_q);
         default: cond = 1'b0;
      endcase
      if (is_jal || (is_br && cond)) begin
         next_pc = bus.pc_out + op3_q;
      end else if (is_jalr) begin
         next_pc = {jalr_sum[XLEN-1:1], 1'b0};
      end
      rd_link  = (rd_q == 5'd1) || (rd_q == 5'd5);
      rs1_link = (rs1_q == 5'd1) || (rs1_q == 5'd5);
      do_push  = (is_jal || is_jalr) && rd_link;
      do_pop   = is_jalr && rs1_link && (!rd_link || (rd_q != rs1_q));
      redir    = (next_pc != pc_plus4);
   end

   // Control FSM, PC / link registers and return-address stack.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= IDLE;
         flush_cnt     <= '0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.redirect  <= 1'b0;
         bus.pc_out    <= RESET_PC;
         bus.ret_addr  <= '0;
         ras_count     <= '0;
         ras_ptr       <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
         opc_q         <= '0;
         f3_q          <= '0;
         rd_q          <= '0;
         rs1_q         <= '0;
         op1_q         <= '0;
         op2_q         <= '0;
         op3_q         <= '0;
`ifdef RAS_PREDICT_EN
         ras_mispredict <= 1'b0;
`endif
      end else begin
         bus.out_valid <= 1'b0;
         bus.redirect  <= 1'b0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
`ifdef RAS_PREDICT_EN
         ras_mispredict <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  opc_q        <= bus.instr[6:0];
                  f3_q         <= bus.instr[14:12];
                  rd_q         <= bus.instr[11:7];
                  rs1_q        <= bus.instr[19:15];
                  op1_q        <= bus.op1;
                  op2_q        <= bus.op2;
                  op3_q        <= bus.op3;
                  bus.in_ready <= 1'b0;
                  state        <= RESOLVE;
               end
            end
            RESOLVE: begin
               bus.out_valid <= 1'b1;
               bus.redirect  <= redir;
               bus.pc_out    <= next_pc;
               if (is_jal || is_jalr) begin
                  bus.ret_addr <= pc_plus4;
               end
               if (do_push && do_pop) begin
                  if (ras_count == '0) begin
                     ras_mem[ras_ptr] <= pc_plus4;
                     ras_ptr          <= ras_ptr + PW'(1);
                     ras_count        <= CW'(1);
                  end else begin
                     ras_mem[top_idx] <= pc_plus4;
                  end
               end else if (do_push) begin
                  ras_mem[ras_ptr] <= pc_plus4;
                  ras_ptr          <= ras_ptr + PW'(1);
                  if (ras_count == CW'(RAS_DEPTH)) begin
                     ras_overflow <= 1'b1;
                  end else begin
                     ras_count <= ras_count + CW'(1);
                  end
               end else if (do_pop) begin
                  if (ras_count == '0) begin
                     ras_underflow <= 1'b1;
                  end else begin
                     ras_ptr   <= top_idx;
                     ras_count <= ras_count - CW'(1);
                  end
               end
`ifdef RAS_PREDICT_EN
               if (do_pop) begin
                  ras_mispredict <= (ras_count == '0) || (next_pc != ras_mem[top_idx]);
               end
`endif
               if (redir) begin
                  flush_cnt <= FW'(FLUSH_CYCLES - 1);
                  state     <= FLUSH;
               end else begin
                  bus.in_ready <= 1'b1;
                  state        <= IDLE;
               end
            end
            FLUSH: begin
               if (flush_cnt == '0) begin
                  bus.in_ready <= 1'b1;
                  state        <= IDLE;
               end else begin
                  flush_cnt <= flush_cnt - FW'(1);
               end
            end
            default: begin
               bus.in_ready <= 1'b1;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule
